// File: rtl/alu16.sv
// 16-bit execute-stage ALU: combinational result path built on 4-bit CLA slices,
// plus a small synchronously reset Z/V/N flag register for the branch logic.

module Alu16Cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       ovfl_o,
  output logic       pout_o,
  output logic       gout_o
);

  logic [3:0] bitP;
  logic [3:0] bitG;
  logic [4:0] carry;

  assign bitP     = a_i ^ b_i;
  assign bitG     = a_i & b_i;
  assign carry[0] = cin_i;
  assign carry[1] = bitG[0] | (bitP[0] & carry[0]);
  assign carry[2] = bitG[1] | (bitP[1] & bitG[0]) | (bitP[1] & bitP[0] & carry[0]);
  assign carry[3] = bitG[2] | (bitP[2] & bitG[1]) | (bitP[2] & bitP[1] & bitG[0])
                  | (bitP[2] & bitP[1] & bitP[0] & carry[0]);

  assign pout_o = &bitP;
  assign gout_o = bitG[3] | (bitP[3] & bitG[2]) | (bitP[3] & bitP[2] & bitG[1])
                | (bitP[3] & bitP[2] & bitP[1] & bitG[0]);
  assign carry[4] = gout_o | (pout_o & carry[0]);

  assign sum_o  = bitP ^ carry[3:0];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovfl_o = carry[3] ^ carry[4];

endmodule

module Alu16ClaChain #(
  parameter int Slices = 4
) (
  input  logic [4*Slices-1:0] a_i,
  input  logic [4*Slices-1:0] b_i,
  input  logic                cin_i,
  output logic [4*Slices-1:0] sum_o,
  output logic                cout_o,
  output logic                ovfl_o
);

  logic [Slices:0]   carry;
  logic [Slices-1:0] sliceP;
  logic [Slices-1:0] sliceG;
  logic [Slices-1:0] sliceOvfl;
  logic              unusedOvfl;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < Slices; i++) begin : gSlice
    Alu16Cla4 uSlice (
      .a_i    (a_i[4*i+3:4*i]),
      .b_i    (b_i[4*i+3:4*i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[4*i+3:4*i]),
      .ovfl_o (sliceOvfl[i]),
      .pout_o (sliceP[i]),
      .gout_o (sliceG[i])
    );
    assign carry[i+1] = sliceG[i] | (sliceP[i] & carry[i]);
  end

  assign cout_o     = carry[Slices];
  assign ovfl_o     = sliceOvfl[Slices-1];
  assign unusedOvfl = ^sliceOvfl;

endmodule

module alu16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Opcode,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  output logic [15:0] out,
  output logic        Error,
  output logic        Z,
  output logic        V,
  output logic        N
);

  logic        isSub;
  logic [15:0] addB;
  logic [15:0] mainSum;
  logic        mainCout;
  logic        mainOvfl;
  logic [15:0] satSum;

  logic [3:0]  padSum [4];
  logic [3:0]  padOvfl;
  logic [3:0]  padP;
  logic [3:0]  padG;
  logic [15:0] padResult;
  logic        padSat;

  logic [7:0]  redNode [15];
  logic [6:0]  redCout;
  logic [6:0]  redOvfl;
  logic [15:0] redResult;

  logic [15:0] sllStage [5];
  logic [15:0] sraStage [5];
  logic [15:0] rorStage [5];

  logic [15:0] result;
  logic        zFlag_q, vFlag_q, nFlag_q;
  logic        zFlag_d, vFlag_d, nFlag_d;
  logic        unusedSignals;

  assign isSub = (Opcode == 4'b0001);
  assign addB  = isSub ? ~in2 : in2;

  // Shared 16-bit adder: ADD/SUB (saturated) and address generation (wrapping).
  Alu16ClaChain #(.Slices(4)) uMainAdd (
    .a_i    (in1),
    .b_i    (addB),
    .cin_i  (isSub),
    .sum_o  (mainSum),
    .cout_o (mainCout),
    .ovfl_o (mainOvfl)
  );

  // On overflow the true result has the sign of in1 for both ADD and SUB.
  assign satSum = mainOvfl ? (in1[15] ? 16'h8000 : 16'h7FFF) : mainSum;

  for (genvar k = 0; k < 4; k++) begin : gPad
    Alu16Cla4 uPadAdd (
      .a_i    (in1[4*k+3:4*k]),
      .b_i    (in2[4*k+3:4*k]),
      .cin_i  (1'b0),
      .sum_o  (padSum[k]),
      .ovfl_o (padOvfl[k]),
      .pout_o (padP[k]),
      .gout_o (padG[k])
    );
    assign padResult[4*k+3:4*k] = padOvfl[k] ? (in1[4*k+3] ? 4'h8 : 4'h7) : padSum[k];
  end

  assign padSat = |padOvfl;

  // Reduction tree: leaves 0..7 are sign-extended nibbles, node 8+j = node 2j + node 2j+1.
  for (genvar k = 0; k < 4; k++) begin : gRedLeaf
    assign redNode[k]   = {{4{in1[4*k+3]}}, in1[4*k+3:4*k]};
    assign redNode[k+4] = {{4{in2[4*k+3]}}, in2[4*k+3:4*k]};
  end

  for (genvar j = 0; j < 7; j++) begin : gRedAdd
    Alu16ClaChain #(.Slices(2)) uRedAdd (
      .a_i    (redNode[2*j]),
      .b_i    (redNode[2*j+1]),
      .cin_i  (1'b0),
      .sum_o  (redNode[8+j]),
      .cout_o (redCout[j]),
      .ovfl_o (redOvfl[j])
    );
  end

  assign redResult = {{8{redNode[14][7]}}, redNode[14]};

  assign sllStage[0] = in1;
  assign sraStage[0] = in1;
  assign rorStage[0] = in1;

  // Logarithmic barrel shifters; only in2[3:0] steers the stages.
  for (genvar k = 0; k < 4; k++) begin : gShift
    localparam int Dist = 1 << k;
    assign sllStage[k+1] = in2[k] ? {sllStage[k][15-Dist:0], {Dist{1'b0}}} : sllStage[k];
    assign sraStage[k+1] = in2[k] ? {{Dist{sraStage[k][15]}}, sraStage[k][15:Dist]} : sraStage[k];
    assign rorStage[k+1] = in2[k] ? {rorStage[k][Dist-1:0], rorStage[k][15:Dist]} : rorStage[k];
  end

  always_comb begin
    result = 16'h0000;
    case (Opcode)
      4'b0000, 4'b0001: result = satSum;
      4'b0010:          result = in1 ^ in2;
      4'b0011:          result = redResult;
      4'b0100:          result = sllStage[4];
      4'b0101:          result = sraStage[4];
      4'b0110:          result = rorStage[4];
      4'b0111:          result = padResult;
      4'b1000, 4'b1001: result = mainSum;
      default:          result = 16'h0000;
    endcase
  end

  assign out   = result;
  assign Error = (Opcode == 4'b0111) & padSat;

  always_comb begin
    zFlag_d = zFlag_q;
    vFlag_d = vFlag_q;
    nFlag_d = nFlag_q;
    case (Opcode)
      4'b0000, 4'b0001: begin
        zFlag_d = (result == 16'h0000);
        nFlag_d = result[15];
        vFlag_d = mainOvfl;
      end
      4'b0010, 4'b0100, 4'b0101, 4'b0110: zFlag_d = (result == 16'h0000);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zFlag_q <= 1'b0;
      vFlag_q <= 1'b0;
      nFlag_q <= 1'b0;
    end else begin
      zFlag_q <= zFlag_d;
      vFlag_q <= vFlag_d;
      nFlag_q <= nFlag_d;
    end
  end

  assign Z = zFlag_q;
  assign V = vFlag_q;
  assign N = nFlag_q;

  assign unusedSignals = ^{mainCout, padP, padG, redCout, redOvfl};

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vector table, flag/reset sequences,
// and randomized operations checked against a plain-arithmetic reference model.

module tb_alu16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Opcode;
  logic [15:0] in1, in2;
  logic [15:0] out;
  logic        Error, Z, V, N;

  int vectors = 0;
  int miscompares = 0;

  logic        mZ = 1'b0, mV = 1'b0, mN = 1'b0;
  logic [15:0] mOut;
  logic        mErr, mUpdZ, mUpdVN, mOvf, mRst;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expOut;
    logic        expErr;
  } vec_t;

  vec_t table_v [24];

  always #5 clk = ~clk;

  alu16 dut (
    .clk    (clk),
    .rst    (rst),
    .Opcode (Opcode),
    .in1    (in1),
    .in2    (in2),
    .out    (out),
    .Error  (Error),
    .Z      (Z),
    .V      (V),
    .N      (N)
  );

  function automatic int nib(input logic [3:0] x);
    return (x >= 4'd8) ? int'(x) - 16 : int'(x);
  endfunction

  // Behavioural reference computed straight from the operation definitions.
  function automatic void refModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] res, output logic err,
                                   output logic updZ, output logic updVN, output logic ovf);
    int s;
    int amt;
    res = 16'h0; err = 1'b0; updZ = 1'b0; updVN = 1'b0; ovf = 1'b0;
    amt = int'(b[3:0]);
    case (op)
      4'd0, 4'd1: begin
        if (op == 4'd0) s = int'($signed(a)) + int'($signed(b));
        else            s = int'($signed(a)) - int'($signed(b));
        if (s > 32767)       begin res = 16'h7FFF; ovf = 1'b1; end
        else if (s < -32768) begin res = 16'h8000; ovf = 1'b1; end
        else                 res = s[15:0];
        updZ = 1'b1; updVN = 1'b1;
      end
      4'd2: begin res = a ^ b; updZ = 1'b1; end
      4'd3: begin
        s = 0;
        for (int i = 0; i < 4; i++) s = s + nib(a[4*i +: 4]) + nib(b[4*i +: 4]);
        res = s[15:0];
      end
      4'd4: begin res = a << amt; updZ = 1'b1; end
      4'd5: begin s = int'($signed(a)); s = s >>> amt; res = s[15:0]; updZ = 1'b1; end
      4'd6: begin s = (int'(a) >> amt) | (int'(a) << (16 - amt)); res = s[15:0]; updZ = 1'b1; end
      4'd7: begin
        for (int i = 0; i < 4; i++) begin
          s = nib(a[4*i +: 4]) + nib(b[4*i +: 4]);
          if (s > 7)  begin s = 7;  err = 1'b1; end
          if (s < -8) begin s = -8; err = 1'b1; end
          res[4*i +: 4] = s[3:0];
        end
      end
      4'd8, 4'd9: res = a + b;
      default: res = 16'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic r);
    @(negedge clk);
    Opcode = op; in1 = a; in2 = b; rst = r;
    mRst = r;
    refModel(op, a, b, mOut, mErr, mUpdZ, mUpdVN, mOvf);
    #1;
  endtask

  task automatic advanceClock(input string name);
    @(posedge clk);
    if (mRst) begin
      mZ = 1'b0; mV = 1'b0; mN = 1'b0;
    end else begin
      if (mUpdZ) mZ = (mOut == 16'h0);
      if (mUpdVN) begin mN = mOut[15]; mV = mOvf; end
    end
    #1;
    checkOutput({name, " Z"}, {15'b0, Z}, {15'b0, mZ});
    checkOutput({name, " V"}, {15'b0, V}, {15'b0, mV});
    checkOutput({name, " N"}, {15'b0, N}, {15'b0, mN});
  endtask

  initial begin
    table_v[0]  = '{4'b0001, 16'h8000, 16'h7FFF, 16'h8000, 1'b0};
    table_v[1]  = '{4'b0000, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0};
    table_v[2]  = '{4'b0000, 16'h0005, 16'hFFFB, 16'h0000, 1'b0};
    table_v[3]  = '{4'b0100, 16'h0001, 16'h0002, 16'h0004, 1'b0};
    table_v[4]  = '{4'b0101, 16'h0008, 16'h0001, 16'h0004, 1'b0};
    table_v[5]  = '{4'b0101, 16'h8000, 16'h000F, 16'hFFFF, 1'b0};
    table_v[6]  = '{4'b0110, 16'h0001, 16'h0002, 16'h4000, 1'b0};
    table_v[7]  = '{4'b0110, 16'h1234, 16'hFFF0, 16'h1234, 1'b0};
    table_v[8]  = '{4'b0100, 16'h0001, 16'hFFFF, 16'h8000, 1'b0};
    table_v[9]  = '{4'b0110, 16'h8001, 16'h000F, 16'h0003, 1'b0};
    table_v[10] = '{4'b0111, 16'h10F7, 16'h1087, 16'h2087, 1'b1};
    table_v[11] = '{4'b0111, 16'h1234, 16'h1111, 16'h2345, 1'b0};
    table_v[12] = '{4'b0011, 16'h1111, 16'hFFFF, 16'h0000, 1'b0};
    table_v[13] = '{4'b0011, 16'h7777, 16'h7777, 16'h0038, 1'b0};
    table_v[14] = '{4'b0011, 16'h8888, 16'h8888, 16'hFFC0, 1'b0};
    table_v[15] = '{4'b0010, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0};
    table_v[16] = '{4'b1000, 16'hFFFF, 16'h0002, 16'h0001, 1'b0};
    table_v[17] = '{4'b1001, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    table_v[18] = '{4'b1010, 16'h1234, 16'h5678, 16'h0000, 1'b0};
    table_v[19] = '{4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0};
    table_v[20] = '{4'b0000, 16'h8000, 16'hFFFF, 16'h8000, 1'b0};
    table_v[21] = '{4'b0001, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0};
    table_v[22] = '{4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
    table_v[23] = '{4'b0101, 16'h7FF0, 16'h0004, 16'h07FF, 1'b0};

    rst = 1'b1; Opcode = 4'h0; in1 = 16'h0; in2 = 16'h0;
    applyStimulus(4'b0000, 16'h0, 16'h0, 1'b1);
    advanceClock("reset");

    for (int i = 0; i < 24; i++) begin
      applyStimulus(table_v[i].op, table_v[i].a, table_v[i].b, 1'b0);
      checkOutput($sformatf("vec%0d out", i), out, table_v[i].expOut);
      checkOutput($sformatf("vec%0d err", i), {15'b0, Error}, {15'b0, table_v[i].expErr});
      advanceClock($sformatf("vec%0d", i));
    end

    applyStimulus(4'b0001, 16'h8000, 16'h7FFF, 1'b0);
    advanceClock("subsat");
    checkOutput("subsat V=1", {15'b0, V}, 16'h0001);
    checkOutput("subsat N=1", {15'b0, N}, 16'h0001);
    checkOutput("subsat Z=0", {15'b0, Z}, 16'h0000);

    applyStimulus(4'b0000, 16'h0005, 16'hFFFB, 1'b0);
    advanceClock("addzero");
    checkOutput("addzero Z=1", {15'b0, Z}, 16'h0001);

    applyStimulus(4'b0001, 16'h8000, 16'h7FFF, 1'b1);
    checkOutput("rst comb out", out, 16'h8000);
    advanceClock("rst sub");
    checkOutput("rst Z=0", {15'b0, Z}, 16'h0000);
    checkOutput("rst V=0", {15'b0, V}, 16'h0000);
    checkOutput("rst N=0", {15'b0, N}, 16'h0000);

    applyStimulus(4'b0001, 16'h8000, 16'h7FFF, 1'b0);
    advanceClock("post-rst sub");
    checkOutput("post-rst V=1", {15'b0, V}, 16'h0001);
    checkOutput("post-rst N=1", {15'b0, N}, 16'h0001);

    applyStimulus(4'b0010, 16'h1234, 16'h1234, 1'b0);
    advanceClock("xor zero");
    checkOutput("xor Z=1", {15'b0, Z}, 16'h0001);
    checkOutput("xor V held", {15'b0, V}, 16'h0001);
    checkOutput("xor N held", {15'b0, N}, 16'h0001);

    applyStimulus(4'b0011, 16'h1111, 16'h1111, 1'b0);
    advanceClock("red hold");
    checkOutput("red Z held", {15'b0, Z}, 16'h0001);

    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      logic        r;
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 0) ? a : 16'hFFFF;
      r = ($urandom_range(0, 19) == 0);
      applyStimulus(op, a, b, r);
      checkOutput($sformatf("rand%0d op%0h out", i, op), out, mOut);
      checkOutput($sformatf("rand%0d op%0h err", i, op), {15'b0, Error}, {15'b0, mErr});
      advanceClock($sformatf("rand%0d op%0h", i, op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
